// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// MEM_ARB_RR_EN selects round-robin tie breaking instead of fixed data priority.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_e;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant picker: data wins ties unless round-robin is enabled,
// in which case the side that was not granted last wins.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter bit RR = 1'b0
) (
    input  logic   req_f,
    input  logic   req_d,
    input  owner_e last,
    output logic   gnt_f,
    output logic   gnt_d
);

    always_comb begin
        gnt_d = req_d && (!req_f || !RR || (last != DATA));
        gnt_f = req_f && !gnt_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store; registered command bus,
// read data routed back to its issuer two edges after the grant (MEM_ARB_RR_EN: round-robin ties).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_f_req,
    input  logic [ADDR_W-1:0] I_f_addr,
    output logic              O_f_gnt,
    output logic              O_f_rvalid,
    output logic [DATA_W-1:0] O_f_rdata,
    input  logic              I_d_req,
    input  logic              I_d_we,
    input  logic [ADDR_W-1:0] I_d_addr,
    input  logic [DATA_W-1:0] I_d_wdata,
    output logic              O_d_gnt,
    output logic              O_d_rvalid,
    output logic [DATA_W-1:0] O_d_rdata,
    output logic              O_mem_en,
    output logic              O_mem_mread,
    output logic [ADDR_W-1:0] O_mem_addr,
    output logic [DATA_W-1:0] O_mem_wdata,
    input  logic [DATA_W-1:0] I_mem_rdata
);

    owner_e owner;
    owner_e resp_owner;
    owner_e last_gnt;
    logic   pick_f;
    logic   pick_d;

    mem_arb_grant #(.RR(RR_EN)) u_grant (
        .req_f (I_f_req),
        .req_d (I_d_req),
        .last  (last_gnt),
        .gnt_f (pick_f),
        .gnt_d (pick_d)
    );

    // No handshake can complete while reset is held.
    assign O_f_gnt = pick_f && rst_n;
    assign O_d_gnt = pick_d && rst_n;

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= FETCH;
        end else if (O_d_gnt) begin
            last_gnt <= DATA;
        end else if (O_f_gnt) begin
            last_gnt <= FETCH;
        end
    end
`else
    assign last_gnt = FETCH;
`endif

    // owner tracks the command on the bus now; resp_owner the one whose data
    // the memory is returning, so a new grant never disturbs a pending reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O_mem_en    <= 1'b0;
            O_mem_mread <= OP_READ;
            O_mem_addr  <= '0;
            O_mem_wdata <= '0;
            owner       <= IDLE;
            resp_owner  <= IDLE;
            O_f_rvalid  <= 1'b0;
            O_d_rvalid  <= 1'b0;
        end else begin
            if (O_d_gnt) begin
                O_mem_en    <= 1'b1;
                O_mem_mread <= I_d_we ? OP_WRITE : OP_READ;
                O_mem_addr  <= I_d_addr;
                O_mem_wdata <= I_d_wdata;
                owner       <= I_d_we ? IDLE : DATA;
            end else if (O_f_gnt) begin
                O_mem_en    <= 1'b1;
                O_mem_mread <= OP_READ;
                O_mem_addr  <= I_f_addr;
                owner       <= FETCH;
            end else begin
                O_mem_en    <= 1'b0;
                owner       <= IDLE;
            end
            resp_owner <= owner;
            O_f_rvalid <= (resp_owner == FETCH);
            O_d_rvalid <= (resp_owner == DATA);
        end
    end

    assign O_f_rdata = O_f_rvalid ? I_mem_rdata : '0;
    assign O_d_rdata = O_d_rvalid ? I_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with a scoreboard on both read-response ports.
// Build with +define+MEM_ARB_RR_EN to select the round-robin contention vectors.
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          I_f_req = 1'b0;
    logic [AW-1:0] I_f_addr = '0;
    logic          O_f_gnt;
    logic          O_f_rvalid;
    logic [DW-1:0] O_f_rdata;
    logic          I_d_req = 1'b0;
    logic          I_d_we = 1'b0;
    logic [AW-1:0] I_d_addr = '0;
    logic [DW-1:0] I_d_wdata = '0;
    logic          O_d_gnt;
    logic          O_d_rvalid;
    logic [DW-1:0] O_d_rdata;
    logic          O_mem_en;
    logic          O_mem_mread;
    logic [AW-1:0] O_mem_addr;
    logic [DW-1:0] O_mem_wdata;
    logic [DW-1:0] I_mem_rdata = '0;

    mem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .I_f_req     (I_f_req),
        .I_f_addr    (I_f_addr),
        .O_f_gnt     (O_f_gnt),
        .O_f_rvalid  (O_f_rvalid),
        .O_f_rdata   (O_f_rdata),
        .I_d_req     (I_d_req),
        .I_d_we      (I_d_we),
        .I_d_addr    (I_d_addr),
        .I_d_wdata   (I_d_wdata),
        .O_d_gnt     (O_d_gnt),
        .O_d_rvalid  (O_d_rvalid),
        .O_d_rdata   (O_d_rdata),
        .O_mem_en    (O_mem_en),
        .O_mem_mread (O_mem_mread),
        .O_mem_addr  (O_mem_addr),
        .O_mem_wdata (O_mem_wdata),
        .I_mem_rdata (I_mem_rdata)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    // Command sampled at the edge after it is driven; read word appears one edge later.
    logic [DW-1:0] mem [0:4095];
    logic          mem_loaded = 1'b0;
    logic          rd_pend = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
            mem[12'h001] <= 32'h40000F83;
            mem[12'h002] <= 32'h00A00093;
            mem[12'h003] <= 32'h00B00113;
            for (int i = 0; i < 6; i++) mem[12'h010 + i] <= 32'hA0000010 + i;
            mem[12'h406] <= 32'hDEADBEEF;
            mem_loaded <= 1'b1;
        end else begin
            rd_pend <= O_mem_en && O_mem_mread;
            rd_addr <= O_mem_addr;
            if (O_mem_en && !O_mem_mread) mem[O_mem_addr] <= O_mem_wdata;
            if (rd_pend) I_mem_rdata <= mem[rd_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int errors  = 0;
    bit mon_en  = 1'b0;

    logic [DW-1:0] exp_f_q[$];
    int            exp_f_cyc_q[$];
    logic [DW-1:0] exp_d_q[$];
    int            exp_d_cyc_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected read of that port.
    always @(negedge clk) begin
        if (mon_en) begin
            if (O_f_rvalid === 1'b1) begin
                if (exp_f_q.size() == 0) begin
                    chk("f_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    chk("f_rdata", O_f_rdata, exp_f_q.pop_front());
                    chk("f_latency", cyc, exp_f_cyc_q.pop_front());
                end
            end else begin
                chk("f_rdata_idle", O_f_rdata, '0);
            end
            if (O_d_rvalid === 1'b1) begin
                if (exp_d_q.size() == 0) begin
                    chk("d_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    chk("d_rdata", O_d_rdata, exp_d_q.pop_front());
                    chk("d_latency", cyc, exp_d_cyc_q.pop_front());
                end
            end else begin
                chk("d_rdata_idle", O_d_rdata, '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_values();
        chk("rst_f_gnt", O_f_gnt, 0);
        chk("rst_d_gnt", O_d_gnt, 0);
        chk("rst_mem_en", O_mem_en, 0);
        chk("rst_mem_mread", O_mem_mread, 1);
        chk("rst_mem_addr", O_mem_addr, 0);
        chk("rst_mem_wdata", O_mem_wdata, 0);
        chk("rst_f_rvalid", O_f_rvalid, 0);
        chk("rst_d_rvalid", O_d_rvalid, 0);
    endtask

    // Holds both requests high during reset so gnt-masking is exercised too.
    task automatic do_reset();
        rst_n   = 1'b0;
        I_f_req = 1'b1;
        I_d_req = 1'b1;
        #1;
        mon_en = 1'b1;
        check_reset_values();
        @(negedge clk);
        check_reset_values();
        I_f_req = 1'b0;
        I_d_req = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; called #1 after a rising edge, returns #1 after the next.
    task automatic vec(input logic fr, input logic [AW-1:0] fa,
                       input logic dr, input logic dwe, input logic [AW-1:0] da,
                       input logic [DW-1:0] dwd, input logic egf, input logic egd,
                       input logic [DW-1:0] exp_rd, input bit push);
        logic gf, gd;
        I_f_req   = fr;
        I_f_addr  = fa;
        I_d_req   = dr;
        I_d_we    = dwe;
        I_d_addr  = da;
        I_d_wdata = dwd;
        @(negedge clk);
        gf = O_f_gnt;
        gd = O_d_gnt;
        chk("f_gnt", gf, egf);
        chk("d_gnt", gd, egd);
        @(posedge clk);
        // cyc still holds its pre-edge value here; the pulse lands after two more edges.
        if (push && gf) begin
            exp_f_q.push_back(exp_rd);
            exp_f_cyc_q.push_back(cyc + 3);
        end
        if (push && gd && !dwe) begin
            exp_d_q.push_back(exp_rd);
            exp_d_cyc_q.push_back(cyc + 3);
        end
        #1;
        if (gd) begin
            chk("bus_en", O_mem_en, 1);
            chk("bus_mread", O_mem_mread, !dwe);
            chk("bus_addr", O_mem_addr, da);
            if (dwe) chk("bus_wdata", O_mem_wdata, dwd);
        end else if (gf) begin
            chk("bus_en", O_mem_en, 1);
            chk("bus_mread", O_mem_mread, 1);
            chk("bus_addr", O_mem_addr, fa);
        end else begin
            chk("bus_en_idle", O_mem_en, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #1;
        do_reset();

        // fetch-only read
        vec(1, 12'h001, 0, 0, 0, 0, 1, 0, 32'h40000F83, 1);
        idle(3);

        // data write then read-back of the same word
        vec(0, 0, 1, 1, 12'h406, 32'h0000001E, 0, 1, 0, 1);
        vec(0, 0, 1, 0, 12'h406, 0, 0, 1, 32'h0000001E, 1);
        idle(3);

        // back-to-back fetch reads
        vec(1, 12'h001, 0, 0, 0, 0, 1, 0, 32'h40000F83, 1);
        vec(1, 12'h002, 0, 0, 0, 0, 1, 0, 32'h00A00093, 1);
        vec(1, 12'h003, 0, 0, 0, 0, 1, 0, 32'h00B00113, 1);
        idle(3);

        // reset one cycle after a data read grant: its response must vanish
        vec(0, 0, 1, 0, 12'h012, 0, 0, 1, 0, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        idle(4);

        // both sides requesting every cycle, fresh from reset
        do_reset();
`ifdef MEM_ARB_RR_EN
        vec(1, 12'h001, 1, 0, 12'h010, 0, 0, 1, 32'hA0000010, 1);
        vec(1, 12'h001, 1, 0, 12'h011, 0, 1, 0, 32'h40000F83, 1);
        vec(1, 12'h002, 1, 0, 12'h011, 0, 0, 1, 32'hA0000011, 1);
        vec(1, 12'h002, 1, 0, 12'h012, 0, 1, 0, 32'h00A00093, 1);
        vec(1, 12'h003, 1, 0, 12'h012, 0, 0, 1, 32'hA0000012, 1);
        vec(1, 12'h003, 1, 0, 12'h013, 0, 1, 0, 32'h00B00113, 1);
`else
        for (int i = 0; i < 6; i++) begin
            vec(1, 12'h003, 1, 0, 12'h010 + 12'(i), 0, 0, 1, 32'hA0000010 + i, 1);
        end
        vec(1, 12'h003, 0, 0, 0, 0, 1, 0, 32'h00B00113, 1);
`endif
        idle(4);

        chk("f_queue_drained", exp_f_q.size(), 0);
        chk("d_queue_drained", exp_d_q.size(), 0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
